// File: rtl/arm_controller.sv
// Control unit for a single-cycle ARMv4 subset core (data-processing, LDR/STR, B).
// Decodes Instr[31:12] into datapath controls and holds NZCV for conditional execution.
module arm_controller (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:12] Instr,
   input  logic [3:0]  ALUFlags,
   output logic [1:0]  RegSrc,
   output logic        RegWrite,
   output logic [1:0]  ImmSrc,
   output logic        ALUSrc,
   output logic [1:0]  ALUControl,
   output logic        MemWrite,
   output logic        MemtoReg,
   output logic        PCSrc
);

   localparam int unsigned COND_W  = 4;
   localparam int unsigned OP_W    = 2;
   localparam int unsigned FUNCT_W = 6;

   logic [COND_W-1:0]  cond;
   logic [OP_W-1:0]    op;
   logic [FUNCT_W-1:0] funct;
   logic [3:0]         rd;
   logic [3:0]         cmd;
   logic [3:0]         unused_rn;

   logic       regw;
   logic       memw;
   logic       branch;
   logic       aluop;
   logic       nowrite;
   logic [1:0] flagw;
   logic [1:0] flagwrite;
   logic       pcs;
   logic       condex;

   logic [1:0] nz;
   logic [1:0] cv;
   logic       flag_n;
   logic       flag_z;
   logic       flag_c;
   logic       flag_v;

   assign cond      = Instr[31:28];
   assign op        = Instr[27:26];
   assign funct     = Instr[25:20];
   assign rd        = Instr[15:12];
   assign cmd       = funct[4:1];
   // Rn is consumed by the datapath register file, not by control.
   assign unused_rn = Instr[19:16];

   // Main decoder: instruction class to datapath selects and raw enables.
   always_comb begin
      RegSrc   = 2'b00;
      ImmSrc   = 2'b00;
      ALUSrc   = 1'b0;
      MemtoReg = 1'b0;
      regw     = 1'b0;
      memw     = 1'b0;
      branch   = 1'b0;
      aluop    = 1'b0;
      case (op)
         2'b00: begin
            ALUSrc = funct[5];
            regw   = 1'b1;
            aluop  = 1'b1;
         end
         2'b01: begin
            ImmSrc = 2'b01;
            ALUSrc = 1'b1;
            if (funct[0]) begin
               MemtoReg = 1'b1;
               regw     = 1'b1;
            end else begin
               RegSrc = 2'b10;
               memw   = 1'b1;
            end
         end
         2'b10: begin
            RegSrc = 2'b01;
            ImmSrc = 2'b10;
            ALUSrc = 1'b1;
            branch = 1'b1;
         end
         default: ;
      endcase
   end

   // ALU decoder: operation select and which flag groups the S bit may update.
   always_comb begin
      ALUControl = 2'b00;
      nowrite    = 1'b0;
      flagw      = 2'b00;
      if (aluop) begin
         case (cmd)
            4'b0100: ALUControl = 2'b00;
            4'b0010: ALUControl = 2'b01;
            4'b0000: ALUControl = 2'b10;
            4'b1100: ALUControl = 2'b11;
            4'b1010: begin
               ALUControl = 2'b01;
               nowrite    = 1'b1;
            end
            default: ALUControl = 2'b00;
         endcase
         flagw[1] = funct[0];
         flagw[0] = funct[0] & ~ALUControl[1];
      end
   end

   assign pcs = ((rd == 4'b1111) & regw) | branch;

   assign flag_n = nz[1];
   assign flag_z = nz[0];
   assign flag_c = cv[1];
   assign flag_v = cv[0];

   // Condition evaluation against the stored flags.
   always_comb begin
      condex = 1'b0;
      case (cond)
         4'b0000: condex = flag_z;
         4'b0001: condex = ~flag_z;
         4'b0010: condex = flag_c;
         4'b0011: condex = ~flag_c;
         4'b0100: condex = flag_n;
         4'b0101: condex = ~flag_n;
         4'b0110: condex = flag_v;
         4'b0111: condex = ~flag_v;
         4'b1000: condex = flag_c & ~flag_z;
         4'b1001: condex = ~flag_c | flag_z;
         4'b1010: condex = (flag_n == flag_v);
         4'b1011: condex = (flag_n != flag_v);
         4'b1100: condex = ~flag_z & (flag_n == flag_v);
         4'b1101: condex = flag_z | (flag_n != flag_v);
         default: condex = 1'b1;
      endcase
   end

   assign flagwrite = flagw & {condex, condex};

   // Flag state; updates land after the edge so an instruction never sees its own result.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         nz <= 2'b00;
         cv <= 2'b00;
      end else begin
         if (flagwrite[1]) nz <= ALUFlags[3:2];
         if (flagwrite[0]) cv <= ALUFlags[1:0];
      end
   end

   assign RegWrite = regw & condex & ~nowrite;
   assign MemWrite = memw & condex;
   assign PCSrc    = pcs & condex;

endmodule

// File: tb/tb_arm_controller.sv
// Scoreboard bench for arm_controller: stimulus pushes expected controls from an
// instruction-level reference model; an independent monitor pops and compares.
module tb_arm_controller;

   typedef struct packed {
      logic [1:0] regsrc;
      logic       regwrite;
      logic [1:0] immsrc;
      logic       alusrc;
      logic [1:0] aluctl;
      logic       memwrite;
      logic       memtoreg;
      logic       pcsrc;
   } out_t;

   typedef struct packed {
      logic [19:0] ins;
      out_t        exp;
   } item_t;

   logic        clk;
   logic        reset;
   logic [31:12] Instr;
   logic [3:0]  ALUFlags;
   logic [1:0]  RegSrc;
   logic        RegWrite;
   logic [1:0]  ImmSrc;
   logic        ALUSrc;
   logic [1:0]  ALUControl;
   logic        MemWrite;
   logic        MemtoReg;
   logic        PCSrc;

   arm_controller dut (
      .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
      .RegSrc(RegSrc), .RegWrite(RegWrite), .ImmSrc(ImmSrc), .ALUSrc(ALUSrc),
      .ALUControl(ALUControl), .MemWrite(MemWrite), .MemtoReg(MemtoReg), .PCSrc(PCSrc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   item_t sq[$];
   int    vectors = 0;
   int    miscompares = 0;

   // Architectural flag state as the program would see it.
   bit mn, mz, mc, mv;
   bit pend_valid, pend_nz, pend_cv;
   bit [3:0] pend_fl;

   function automatic bit cond_ok(input bit [3:0] c);
      case (c)
         4'h0: return mz;
         4'h1: return !mz;
         4'h2: return mc;
         4'h3: return !mc;
         4'h4: return mn;
         4'h5: return !mn;
         4'h6: return mv;
         4'h7: return !mv;
         4'h8: return mc && !mz;
         4'h9: return !mc || mz;
         4'hA: return mn == mv;
         4'hB: return mn != mv;
         4'hC: return !mz && (mn == mv);
         4'hD: return mz || (mn != mv);
         default: return 1'b1;
      endcase
   endfunction

   function automatic out_t model(input logic [19:0] ins, output bit we_nz, output bit we_cv);
      bit [3:0] c;
      bit [1:0] op;
      bit [5:0] fn;
      bit [3:0] rd;
      bit [3:0] cmd;
      bit pass, is_dp, is_ld, is_st, is_b, is_cmp, writes;
      out_t o;
      c  = ins[19:16];
      op = ins[15:14];
      fn = ins[13:8];
      rd = ins[3:0];
      cmd = fn[4:1];
      pass   = cond_ok(c);
      is_dp  = (op == 2'd0);
      is_ld  = (op == 2'd1) && fn[0];
      is_st  = (op == 2'd1) && !fn[0];
      is_b   = (op == 2'd2);
      is_cmp = is_dp && (cmd == 4'd10);
      writes = is_dp || is_ld;
      o = '0;
      if (is_dp) begin
         case (cmd)
            4'd2, 4'd10: o.aluctl = 2'd1;
            4'd0:        o.aluctl = 2'd2;
            4'd12:       o.aluctl = 2'd3;
            default:     o.aluctl = 2'd0;
         endcase
      end
      o.alusrc   = (is_dp && fn[5]) || is_ld || is_st || is_b;
      o.immsrc   = (is_ld || is_st) ? 2'd1 : (is_b ? 2'd2 : 2'd0);
      o.regsrc   = is_st ? 2'd2 : (is_b ? 2'd1 : 2'd0);
      o.memtoreg = is_ld;
      o.regwrite = writes && pass && !is_cmp;
      o.memwrite = is_st && pass;
      o.pcsrc    = ((writes && rd == 4'hF) || is_b) && pass;
      we_nz = is_dp && fn[0] && pass;
      we_cv = we_nz && (o.aluctl == 2'd0 || o.aluctl == 2'd1);
      return o;
   endfunction

   // Drive one vector now and queue what the controls must be.
   task automatic drive(input logic [19:0] ins, input logic [3:0] fl);
      item_t it;
      bit wn, wc;
      Instr    = ins;
      ALUFlags = fl;
      it.ins = ins;
      it.exp = model(ins, wn, wc);
      sq.push_back(it);
      pend_valid = 1'b1;
      pend_nz = wn;
      pend_cv = wc;
      pend_fl = fl;
   endtask

   // Retire the previous vector's flag update at the edge, then drive the next one.
   task automatic apply(input logic [19:0] ins, input logic [3:0] fl);
      @(posedge clk);
      #1;
      if (pend_valid && !reset) begin
         if (pend_nz) begin mn = pend_fl[3]; mz = pend_fl[2]; end
         if (pend_cv) begin mc = pend_fl[1]; mv = pend_fl[0]; end
      end
      pend_valid = 1'b0;
      drive(ins, fl);
   endtask

   // Monitor: outputs are combinational, so sample shortly after each drive.
   initial begin
      item_t it;
      out_t  act;
      forever begin
         wait (sq.size() != 0);
         #2;
         it = sq.pop_front();
         act = '{RegSrc, RegWrite, ImmSrc, ALUSrc, ALUControl, MemWrite, MemtoReg, PCSrc};
         vectors++;
         if (act !== it.exp) begin
            miscompares++;
            $display("FAIL ctrl instr=%05h got=%03h expected=%03h (regsrc,regw,immsrc,alusrc,aluctl,memw,mem2reg,pcsrc)",
                     it.ins, act, it.exp);
         end
      end
   end

   logic [3:0] cmds [5];

   initial begin
      logic [19:0] r;
      cmds[0] = 4'd4; cmds[1] = 4'd2; cmds[2] = 4'd0; cmds[3] = 4'd12; cmds[4] = 4'd10;
      mn = 0; mz = 0; mc = 0; mv = 0;
      pend_valid = 0; pend_nz = 0; pend_cv = 0; pend_fl = '0;
      reset = 1'b1;
      Instr = '0;
      ALUFlags = '0;
      repeat (2) @(posedge clk);
      apply(20'hE0855, 4'b0000);
      #4 reset = 1'b0;

      apply(20'hE0855, 4'b0000);
      apply(20'hE2802, 4'b0000);
      apply(20'hE1550, 4'b0100);
      apply(20'h0A000, 4'b0000);
      apply(20'hE1550, 4'b0000);
      apply(20'h0A000, 4'b0000);
      apply(20'hE5912, 4'b0000);
      apply(20'hE5812, 4'b0000);
      apply(20'hE08FF, 4'b0000);

      // Set Z, confirm it took, then reset mid-cycle and check flags clear at once.
      apply(20'hE1550, 4'b0100);
      apply(20'h00855, 4'b0000);
      #4 reset = 1'b1;
      mn = 0; mz = 0; mc = 0; mv = 0;
      pend_valid = 1'b0;
      #1 drive(20'h00855, 4'b0000);
      apply(20'h10855, 4'b0000);
      #3 reset = 1'b0;

      for (int i = 0; i < 400; i++) begin
         r = 20'($urandom);
         if ($urandom_range(0, 1) == 1) r[12:9] = cmds[$urandom_range(0, 4)];
         if ($urandom_range(0, 3) == 0) r[19:16] = 4'hE;
         apply(r, 4'($urandom));
      end

      @(posedge clk);
      #5;
      if (sq.size() != 0) begin
         miscompares++;
         $display("FAIL drain pending=%0d expected=0", sq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
